// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle controller for the register-file + ALU + write-back datapath
// Accepts one LI or ALU instruction per handshake and steps it through READ/EXEC/WRITE.
module datapath_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Instr_Valid,
  output logic                  Instr_Ready,
  input  logic                  Instr_Kind,
  input  logic [OP_WIDTH-1:0]   Instr_Opcode,
  input  logic [ADDR_WIDTH-1:0] Instr_Rs1,
  input  logic [ADDR_WIDTH-1:0] Instr_Rs2,
  input  logic [ADDR_WIDTH-1:0] Instr_Rd,
  input  logic [DATA_WIDTH-1:0] Instr_Imm,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [ADDR_WIDTH-1:0] Read_Addr_2,
  output logic [ADDR_WIDTH-1:0] Write_Addr,
  output logic                  Write_Enable,
  output logic                  Mux_ctrl,
  output logic [OP_WIDTH-1:0]   opcode,
  output logic [DATA_WIDTH-1:0] Data_in,
  output logic                  Done,
  output logic                  Zero_Flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  kind_q, kind_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  zero_flag_q, zero_flag_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= 1'b0;
      opcode_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      opcode_q    <= opcode_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  // Fields are only captured in IDLE, so Instr_* is ignored while an instruction is in flight.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    opcode_d    = opcode_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (Instr_Valid) begin
          kind_d   = Instr_Kind;
          opcode_d = Instr_Opcode;
          rs1_d    = Instr_Rs1;
          rs2_d    = Instr_Rs2;
          rd_d     = Instr_Rd;
          imm_d    = Instr_Imm;
          state_d  = Instr_Kind ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        zero_flag_d = zero;
        state_d     = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic in_write;
  logic alu_busy;

  always_comb begin
    in_write     = (state_q == ST_WRITE);
    alu_busy     = (state_q != ST_IDLE) && kind_q;
    Instr_Ready  = (state_q == ST_IDLE) && !Reset;
    Read_Addr_1  = alu_busy ? rs1_q : '0;
    Read_Addr_2  = alu_busy ? rs2_q : '0;
    opcode       = alu_busy ? opcode_q : '0;
    Write_Addr   = in_write ? rd_q : '0;
    Write_Enable = in_write;
    Done         = in_write;
    Mux_ctrl     = in_write && kind_q;
    Data_in      = (in_write && !kind_q) ? imm_q : '0;
    Zero_Flag    = zero_flag_q;
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - bench for datapath_sequencer with register-file/ALU environment
// Expected register contents and zero flag come from an instruction-level model.
module tb_datapath_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Instr_Valid;
  logic          Instr_Ready;
  logic          Instr_Kind;
  logic [OW-1:0] Instr_Opcode;
  logic [AW-1:0] Instr_Rs1, Instr_Rs2, Instr_Rd;
  logic [DW-1:0] Instr_Imm;
  logic          zero;
  logic [AW-1:0] Read_Addr_1, Read_Addr_2, Write_Addr;
  logic          Write_Enable, Mux_ctrl, Done, Zero_Flag;
  logic [OW-1:0] opcode;
  logic [DW-1:0] Data_in;

  datapath_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .Clock(Clock), .Reset(Reset), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Instr_Kind(Instr_Kind), .Instr_Opcode(Instr_Opcode), .Instr_Rs1(Instr_Rs1),
    .Instr_Rs2(Instr_Rs2), .Instr_Rd(Instr_Rd), .Instr_Imm(Instr_Imm), .zero(zero),
    .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2), .Write_Addr(Write_Addr),
    .Write_Enable(Write_Enable), .Mux_ctrl(Mux_ctrl), .opcode(opcode), .Data_in(Data_in),
    .Done(Done), .Zero_Flag(Zero_Flag)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return {31'b0, ($signed(a) < $signed(b))};
    endcase
  endfunction

  // Datapath environment: register file plus ALU driven by the sequencer outputs.
  logic [DW-1:0] env_rf [32];
  logic          rf_clear;
  logic [DW-1:0] alu_res;

  always_comb alu_res = alu_f(opcode, env_rf[Read_Addr_1], env_rf[Read_Addr_2]);
  assign zero = (alu_res == '0);

  always @(posedge Clock) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= '0;
    end else if (Write_Enable) begin
      env_rf[Write_Addr] <= Mux_ctrl ? alu_res : Data_in;
    end
  end

  logic [DW-1:0] model_rf [32];
  logic          model_zero;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields(input logic k, input logic [OW-1:0] op, input logic [AW-1:0] rs1,
                              input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                              input logic [DW-1:0] imm);
    Instr_Kind   = k;
    Instr_Opcode = op;
    Instr_Rs1    = rs1;
    Instr_Rs2    = rs2;
    Instr_Rd     = rd;
    Instr_Imm    = imm;
  endtask

  task automatic junk_inputs();
    logic [31:0] r;
    r = $urandom;
    Instr_Valid = r[0];
    drive_fields(r[1], r[4:2], r[9:5], r[14:10], r[19:15], $urandom);
  endtask

  task automatic wait_ready();
    int waited;
    waited = 0;
    while (Instr_Ready !== 1'b1 && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    check("ready_wait", 32'(Instr_Ready), 32'd1);
  endtask

  // One full instruction, checked cycle by cycle; garbage is driven while the DUT is busy.
  task automatic issue(input logic k, input logic [OW-1:0] op, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic [DW-1:0] imm);
    int lat;
    logic [DW-1:0] res;
    wait_ready();
    drive_fields(k, op, rs1, rs2, rd, imm);
    Instr_Valid = 1'b1;
    lat = k ? 3 : 1;
    res = k ? alu_f(op, model_rf[rs1], model_rf[rs2]) : imm;
    for (int c = 1; c <= lat; c++) begin
      @(negedge Clock);
      check("busy_ready", 32'(Instr_Ready), 32'd0);
      check("we_timing", 32'(Write_Enable), 32'(c == lat));
      check("done_timing", 32'(Done), 32'(c == lat));
      if (k) begin
        check("read_addr_1", 32'(Read_Addr_1), 32'(rs1));
        check("read_addr_2", 32'(Read_Addr_2), 32'(rs2));
        check("alu_opcode", 32'(opcode), 32'(op));
      end
      if (c == lat) begin
        check("write_addr", 32'(Write_Addr), 32'(rd));
        check("mux_ctrl", 32'(Mux_ctrl), 32'(k));
        if (!k) check("data_in", Data_in, imm);
      end
      junk_inputs();
    end
    @(negedge Clock);
    Instr_Valid = 1'b0;
    if (k) model_zero = (res == '0);
    model_rf[rd] = res;
    check("idle_ready", 32'(Instr_Ready), 32'd1);
    check("done_clear", 32'(Done), 32'd0);
    check("we_clear", 32'(Write_Enable), 32'd0);
    check("zero_flag", 32'(Zero_Flag), 32'(model_zero));
    check("rf_commit", env_rf[rd], model_rf[rd]);
  endtask

  logic [31:0]   r;
  logic          rk;
  logic [OW-1:0] ops [3];
  logic [AW-1:0] s1s [3], s2s [3], rds [3];
  int            n, done_cnt;

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    model_zero  = 1'b0;
    rf_clear    = 1'b1;
    Reset       = 1'b1;
    Instr_Valid = 1'b0;
    drive_fields(1'b0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge Clock);
    Reset    = 1'b0;
    rf_clear = 1'b0;
    @(negedge Clock);

    check("rst_ready", 32'(Instr_Ready), 32'd1);
    check("rst_we", 32'(Write_Enable), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_zero_flag", 32'(Zero_Flag), 32'd0);
    check("rst_raddr1", 32'(Read_Addr_1), 32'd0);
    check("rst_raddr2", 32'(Read_Addr_2), 32'd0);
    check("rst_waddr", 32'(Write_Addr), 32'd0);

    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2);
    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd3);
    check("t2_r0", env_rf[0], 32'd2);
    check("t2_r1", env_rf[1], 32'd3);

    issue(1'b1, 3'd0, 5'd0, 5'd1, 5'd2, 32'd0);
    check("t3_r2", env_rf[2], 32'd5);
    check("t3_zero_flag", 32'(Zero_Flag), 32'd0);

    issue(1'b1, 3'd0, 5'd3, 5'd3, 5'd4, 32'd0);
    check("t4_zero_flag", 32'(Zero_Flag), 32'd1);
    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd5, 32'd7);
    check("t4_zero_hold", 32'(Zero_Flag), 32'd1);
    check("t4_r5", env_rf[5], 32'd7);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      repeat (r[25:24]) begin
        @(negedge Clock);
        check("gap_done", 32'(Done), 32'd0);
        check("gap_zero_hold", 32'(Zero_Flag), 32'(model_zero));
      end
      issue(r[0], r[3:1], {2'b0, r[6:4]}, {2'b0, r[9:7]}, {2'b0, r[12:10]},
            r[13] ? {16'b0, r[31:16]} : 32'd0);
    end

    // Valid held high across three back-to-back ALU ops.
    for (int j = 0; j < 3; j++) begin
      r = $urandom;
      ops[j] = r[2:0];
      s1s[j] = {2'b0, r[5:3]};
      s2s[j] = {2'b0, r[8:6]};
      rds[j] = {2'b0, r[11:9]};
    end
    wait_ready();
    drive_fields(1'b1, ops[0], s1s[0], s2s[0], rds[0], '0);
    Instr_Valid = 1'b1;
    n = 1;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clock);
      check("b2b_ready", 32'(Instr_Ready), 32'((cyc % 4) == 0));
      if (Done === 1'b1) begin
        r = alu_f(ops[done_cnt], model_rf[s1s[done_cnt]], model_rf[s2s[done_cnt]]);
        model_rf[rds[done_cnt]] = r;
        model_zero = (r == '0);
        done_cnt++;
      end
      if (Instr_Ready === 1'b1) begin
        if (n < 3) begin
          drive_fields(1'b1, ops[n], s1s[n], s2s[n], rds[n], '0);
          n++;
        end else begin
          Instr_Valid = 1'b0;
        end
      end
    end
    Instr_Valid = 1'b0;
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    check("b2b_accepts", 32'(n), 32'd3);
    check("b2b_zero_flag", 32'(Zero_Flag), 32'(model_zero));
    for (int i = 0; i < 8; i++) check("b2b_rf", env_rf[i], model_rf[i]);

    // Reset during EXEC drops the instruction; a handshake under Reset is refused.
    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd6, 32'hDEAD_BEEF);
    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd1);
    wait_ready();
    drive_fields(1'b1, 3'd0, 5'd1, 5'd1, 5'd6, '0);
    Instr_Valid = 1'b1;
    @(negedge Clock);
    Instr_Valid = 1'b0;
    @(negedge Clock);
    check("t6_in_exec", 32'(Read_Addr_1), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("t6_rst_we", 32'(Write_Enable), 32'd0);
    check("t6_rst_done", 32'(Done), 32'd0);
    check("t6_rst_ready", 32'(Instr_Ready), 32'd0);
    check("t6_rst_zero", 32'(Zero_Flag), 32'd0);
    check("t6_rst_raddr", 32'(Read_Addr_1), 32'd0);
    check("t6_rst_opcode", 32'(opcode), 32'd0);
    check("t6_rst_mux", 32'(Mux_ctrl), 32'd0);
    check("t6_rst_data", Data_in, 32'd0);
    drive_fields(1'b0, 3'd0, 5'd0, 5'd0, 5'd7, 32'h1234);
    Instr_Valid = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    Instr_Valid = 1'b0;
    model_zero = 1'b0;
    #1;
    check("t6_ready_after", 32'(Instr_Ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("t6_no_we", 32'(Write_Enable), 32'd0);
      check("t6_no_done", 32'(Done), 32'd0);
      check("t6_idle_ready", 32'(Instr_Ready), 32'd1);
    end
    check("t6_r6_kept", env_rf[6], 32'hDEAD_BEEF);
    check("t6_r7_kept", env_rf[7], model_rf[7]);
    check("t6_zero_flag", 32'(Zero_Flag), 32'(model_zero));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
